// File: rtl/booth_multiplier_seq_if.sv
// Start/busy/done handshake and operand/result bus for the sequential Booth multiplier.
interface booth_multiplier_seq_if #(parameter int WIDTH = 32);
  logic                 start;
  logic [WIDTH-1:0]     Multiplicand;
  logic [WIDTH-1:0]     Multiplier;
  logic [2*WIDTH-1:0]   Z;
  logic                 busy;
  logic                 done;

  modport master (output start, Multiplicand, Multiplier, input Z, busy, done);
  modport slave  (input start, Multiplicand, Multiplier, output Z, busy, done);
endinterface

// File: rtl/booth_multiplier_seq.sv
// Radix-2 Booth signed multiplier, one multiplier bit per clock; product packed {HI,LO}.
module booth_multiplier_seq #(
  parameter int WIDTH = 32
) (
  input logic                   clock,
  input logic                   reset,
  booth_multiplier_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH:0]     m_q, a_q;
  logic [WIDTH-1:0]   q_q;
  logic               qm1_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] z_q;
  logic               load, step, last;
  logic [WIDTH:0]     a_sum, a_shr;
  logic [WIDTH-1:0]   q_shr;

  // A carries one guard bit so negating M = -2^(WIDTH-1) cannot overflow.
  always_comb begin
    a_sum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    a_shr = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_shr = {a_sum[0], q_q[WIDTH-1:1]};
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        load      = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_q   <= '0;
      a_q   <= '0;
      q_q   <= '0;
      qm1_q <= 1'b0;
      cnt_q <= '0;
      z_q   <= '0;
    end else if (load) begin
      m_q   <= {bus.Multiplicand[WIDTH-1], bus.Multiplicand};
      a_q   <= '0;
      q_q   <= bus.Multiplier;
      qm1_q <= 1'b0;
      cnt_q <= '0;
    end else if (step) begin
      a_q   <= a_shr;
      q_q   <= q_shr;
      qm1_q <= q_q[0];
      cnt_q <= cnt_q + 1'b1;
      // Only the final step publishes, so Z never exposes partial products.
      if (last) z_q <= {a_shr[WIDTH-1:0], q_shr};
    end
  end

  assign bus.Z    = z_q;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Scoreboarded bench for booth_multiplier_seq: directed corner products, start-hold, reset abort, random issue.
module tb_booth_multiplier_seq;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  booth_multiplier_seq_if #(.WIDTH(W)) bus ();

  booth_multiplier_seq #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] sbq[$];
  logic [63:0] last_z;
  int          load_edge, last_free;
  bit          in_flight, mon_en;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] m, input logic [31:0] q);
    longint a, b;
    a = longint'($signed(m));
    b = longint'($signed(q));
    return 64'(a * b);
  endfunction

  // One cycle: advance to the falling edge and check outputs against the timing model.
  task automatic tick();
    bit exp_busy, exp_done;
    @(negedge clock);
    if (!mon_en) return;
    exp_busy = in_flight && (cyc >= load_edge) && (cyc < load_edge + W);
    exp_done = in_flight && (cyc == load_edge + W);
    chk("busy", 64'(bus.busy), 64'(exp_busy));
    chk("done", 64'(bus.done), 64'(exp_done));
    if (exp_done) begin
      in_flight = 1'b0;
      if (sbq.size() == 0) chk("sb_empty", 64'd1, 64'd0);
      else last_z = sbq.pop_front();
    end
    chk(exp_done ? "z_result" : "z_hold", bus.Z, last_z);
  endtask

  task automatic wait_free();
    int n = 0;
    while (in_flight || cyc < last_free) begin
      tick();
      if (++n > 200) begin
        chk("free_timeout", 64'd1, 64'd0);
        return;
      end
    end
  endtask

  // Drive a load on the next rising edge; the operands are scrambled afterwards.
  task automatic issue(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp);
    wait_free();
    bus.start        = 1'b1;
    bus.Multiplicand = m;
    bus.Multiplier   = q;
    load_edge = cyc + 1;
    last_free = load_edge + W + 1;
    in_flight = 1'b1;
    sbq.push_back(exp);
    tick();
    bus.start        = 1'b0;
    bus.Multiplicand = $urandom();
    bus.Multiplier   = $urandom();
  endtask

  initial begin
    logic [31:0] m, q;
    int n;
    bus.start = 1'b0;
    bus.Multiplicand = '0;
    bus.Multiplier   = '0;
    last_z = '0; in_flight = 1'b0; mon_en = 1'b0;
    load_edge = 0; last_free = 0;

    repeat (3) tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("rst_z", bus.Z, 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    tick();

    issue(32'd7, 32'd6, 64'h0000_0000_0000_002A);
    issue(32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    issue(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    issue(32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000);
    issue(32'd0, 32'h8000_0000, 64'd0);

    // start held high through RUN and DONE with changing operands.
    issue(32'd12345, 32'hFFFF_FF00, ref_mul(32'd12345, 32'hFFFF_FF00));
    bus.start = 1'b1;
    while (cyc < last_free) begin
      bus.Multiplicand = $urandom();
      bus.Multiplier   = $urandom();
      tick();
    end
    m = 32'h7FFF_FFFF; q = 32'h7FFF_FFFF;
    issue(m, q, 64'h3FFF_FFFF_0000_0001);

    // Abort mid-run: no done afterwards, Z cleared.
    issue(32'd99, 32'd99, 64'd9801);
    repeat (9) tick();
    reset = 1'b1;
    sbq.delete();
    in_flight = 1'b0;
    last_z    = '0;
    tick();
    reset = 1'b0;
    chk("abort_z", bus.Z, 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    repeat (W + 8) tick();
    last_free = cyc;
    issue(32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);

    for (int i = 0; i < 1000; i++) begin
      m = $urandom();
      q = $urandom();
      if (i % 97 == 0) m = 32'h8000_0000;
      if (i % 89 == 0) q = 32'hFFFF_FFFF;
      issue(m, q, ref_mul(m, q));
    end

    n = 0;
    while (sbq.size() != 0 || in_flight) begin
      tick();
      if (++n > 200) begin
        chk("drain_timeout", 64'd1, 64'd0);
        break;
      end
    end
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
